// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (I) and data (D),
// runs a fixed-latency access, returns registered read data with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IReq,
  input  logic [WIDTH-1:0] IAddr,
  output logic [WIDTH-1:0] IRD,
  output logic             IReady,
  input  logic             DReq,
  input  logic             DWE,
  input  logic [WIDTH-1:0] DAddr,
  input  logic [WIDTH-1:0] DWD,
  output logic [WIDTH-1:0] DRD,
  output logic             DReady,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWD,
  output logic             MemWE,
  input  logic [WIDTH-1:0] MemRD,
  output logic             StallF,
  output logic             StallM
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate effective requests
  // ACCESS | memory busy for LATENCY cycles on behalf of grant
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          grant, grant_nxt;            // 1 = D, 0 = I
  logic          last_grant, last_grant_nxt;
  logic          lat_we;
  logic          i_eff, d_eff;
  logic          start, done;

  // A requester is ignored in its own Ready cycle so it cannot be re-served on a stale request.
  assign i_eff  = IReq & ~IReady;
  assign d_eff  = DReq & ~DReady;
  assign StallF = IReq & ~IReady;
  assign StallM = DReq & ~DReady;

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    start          = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (i_eff | d_eff) begin
          start          = 1'b1;
          grant_nxt      = (i_eff & d_eff) ? ~last_grant : d_eff;
          last_grant_nxt = grant_nxt;
          count_nxt      = CW'(LATENCY - 1);
          state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        if (count != '0) begin
          count_nxt = count - CW'(1);
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IRD     <= '0;
      DRD     <= '0;
      MemAddr <= '0;
      MemWD   <= '0;
      MemWE   <= 1'b0;
      IReady  <= 1'b0;
      DReady  <= 1'b0;
      lat_we  <= 1'b0;
    end else begin
      IReady <= 1'b0;
      DReady <= 1'b0;
      MemWE  <= 1'b0;
      if (start) begin
        if (grant_nxt) begin
          MemAddr <= DAddr;
          MemWD   <= DWD;
          lat_we  <= DWE;
          MemWE   <= DWE;   // high for the first ACCESS cycle only: one write per store
        end else begin
          MemAddr <= IAddr;
          lat_we  <= 1'b0;
        end
      end
      if (done) begin
        if (grant) begin
          if (!lat_we) DRD <= MemRD;
          DReady <= 1'b1;
        end else begin
          IRD    <= MemRD;
          IReady <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle trace table on a LATENCY=1 instance,
// plus hand sequences for store, mid-access reset and fairness on LATENCY=1/3 instances.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwd = '0;

  logic [31:0] ird1, drd1, mem_addr1, mem_wd1, mem_rd1;
  logic        iready1, dready1, mem_we1, stallf1, stallm1;
  logic [31:0] ird3, drd3, mem_addr3, mem_wd3, mem_rd3;
  logic        iready3, dready3, mem_we3, stallf3, stallm3;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h2008_0005 : ~a;
  endfunction

  assign mem_rd1 = rd_model(mem_addr1);
  assign mem_rd3 = rd_model(mem_addr3);

  mem_port_arbiter #(.LATENCY(1), .WIDTH(32)) u1 (
    .clock(clock), .reset(reset),
    .IReq(ireq), .IAddr(iaddr), .IRD(ird1), .IReady(iready1),
    .DReq(dreq), .DWE(dwe), .DAddr(daddr), .DWD(dwd), .DRD(drd1), .DReady(dready1),
    .MemAddr(mem_addr1), .MemWD(mem_wd1), .MemWE(mem_we1), .MemRD(mem_rd1),
    .StallF(stallf1), .StallM(stallm1));

  mem_port_arbiter #(.LATENCY(3), .WIDTH(32)) u3 (
    .clock(clock), .reset(reset),
    .IReq(ireq), .IAddr(iaddr), .IRD(ird3), .IReady(iready3),
    .DReq(dreq), .DWE(dwe), .DAddr(daddr), .DWD(dwd), .DRD(drd3), .DReady(dready3),
    .MemAddr(mem_addr3), .MemWD(mem_wd3), .MemWE(mem_we3), .MemRD(mem_rd3),
    .StallF(stallf3), .StallM(stallm3));

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        e_iready, e_dready, e_stallf, e_stallm;
    logic [31:0] e_memaddr, e_ird, e_drd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [31:0] da, input logic eir, input logic edr,
                               input logic esf, input logic esm, input logic [31:0] ema,
                               input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.daddr = da;
    v.e_iready = eir; v.e_dready = edr; v.e_stallf = esf; v.e_stallm = esm;
    v.e_memaddr = ema; v.e_ird = eird; v.e_drd = edrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic exp_d;
    vecs[0]  = mkv(1, 32'h0040_0000, 0, 32'h0, 0, 0, 1, 0, 32'h0,          32'h0,          32'h0);
    vecs[1]  = mkv(1, 32'h0040_0000, 0, 32'h0, 0, 0, 1, 0, 32'h0040_0000, 32'h0,          32'h0);
    vecs[2]  = mkv(1, 32'h0040_0000, 0, 32'h0, 1, 0, 0, 0, 32'h0040_0000, 32'h2008_0005, 32'h0);
    vecs[3]  = mkv(0, 32'h0040_0000, 0, 32'h0, 0, 0, 0, 0, 32'h0040_0000, 32'h2008_0005, 32'h0);
    vecs[4]  = mkv(0, 32'h0040_0000, 0, 32'h0, 0, 0, 0, 0, 32'h0040_0000, 32'h2008_0005, 32'h0);
    vecs[5]  = mkv(1, 32'h0040_0004, 1, 32'h7FFF_FFFC, 0, 0, 1, 1, 32'h0040_0000, 32'h2008_0005, 32'h0);
    vecs[6]  = mkv(1, 32'h0040_0004, 1, 32'h7FFF_FFFC, 0, 0, 1, 1, 32'h7FFF_FFFC, 32'h2008_0005, 32'h0);
    vecs[7]  = mkv(1, 32'h0040_0004, 1, 32'h7FFF_FFFC, 0, 1, 1, 0, 32'h7FFF_FFFC, 32'h2008_0005, 32'h8000_0003);
    vecs[8]  = mkv(1, 32'h0040_0004, 0, 32'h7FFF_FFFC, 0, 0, 1, 0, 32'h0040_0004, 32'h2008_0005, 32'h8000_0003);
    vecs[9]  = mkv(0, 32'h0040_0004, 0, 32'h7FFF_FFFC, 1, 0, 0, 0, 32'h0040_0004, 32'hFFBF_FFFB, 32'h8000_0003);
    vecs[10] = mkv(1, 32'h0040_0100, 0, 32'h7FFF_FFFC, 0, 0, 1, 0, 32'h0040_0004, 32'hFFBF_FFFB, 32'h8000_0003);
    vecs[11] = mkv(0, 32'h0040_0200, 0, 32'h7FFF_FFFC, 0, 0, 0, 0, 32'h0040_0100, 32'hFFBF_FFFB, 32'h8000_0003);
    vecs[12] = mkv(0, 32'h0040_0200, 0, 32'h7FFF_FFFC, 1, 0, 0, 0, 32'h0040_0100, 32'hFFBF_FEFF, 32'h8000_0003);
    vecs[13] = mkv(1, 32'h0040_0200, 0, 32'h7FFF_FFFC, 0, 0, 1, 0, 32'h0040_0100, 32'hFFBF_FEFF, 32'h8000_0003);
    vecs[14] = mkv(1, 32'h0040_0200, 0, 32'h7FFF_FFFC, 0, 0, 1, 0, 32'h0040_0200, 32'hFFBF_FEFF, 32'h8000_0003);
    vecs[15] = mkv(0, 32'h0040_0200, 0, 32'h7FFF_FFFC, 1, 0, 0, 0, 32'h0040_0200, 32'hFFBF_FDFF, 32'h8000_0003);

    // reset values on both instances
    tick();
    chk("rst_ird1", ird1, 0);       chk("rst_drd1", drd1, 0);
    chk("rst_memaddr1", mem_addr1, 0); chk("rst_memwd1", mem_wd1, 0);
    chk("rst_rdy1", {30'b0, iready1, dready1}, 0); chk("rst_memwe1", mem_we1, 0);
    chk("rst_memaddr3", mem_addr3, 0); chk("rst_rdy3", {30'b0, iready3, dready3}, 0);
    reset = 1'b0;

    // cycle trace on LATENCY=1: fetch, conflict, drop/change mid-access
    for (int i = 0; i < 16; i++) begin
      ireq = vecs[i].ireq; iaddr = vecs[i].iaddr;
      dreq = vecs[i].dreq; daddr = vecs[i].daddr; dwe = 1'b0; dwd = '0;
      #1;
      chk($sformatf("v%0d_iready", i), iready1, vecs[i].e_iready);
      chk($sformatf("v%0d_dready", i), dready1, vecs[i].e_dready);
      chk($sformatf("v%0d_stallf", i), stallf1, vecs[i].e_stallf);
      chk($sformatf("v%0d_stallm", i), stallm1, vecs[i].e_stallm);
      chk($sformatf("v%0d_memaddr", i), mem_addr1, vecs[i].e_memaddr);
      chk($sformatf("v%0d_memwe", i), mem_we1, 0);
      chk($sformatf("v%0d_ird", i), ird1, vecs[i].e_ird);
      chk($sformatf("v%0d_drd", i), drd1, vecs[i].e_drd);
      tick();
    end

    // both held continuously: strict alternation starting with D (last grant was I)
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; daddr = 32'h7FFF_FFFC; iaddr = 32'h0040_0000;
    seen = 0; exp_d = 1'b1;
    for (int c = 0; c < 40 && seen < 8; c++) begin
      tick();
      if (iready1 | dready1) begin
        chk("alt_no_overlap", {31'b0, iready1 & dready1}, 0);
        chk($sformatf("alt_grant%0d", seen), dready1, exp_d);
        exp_d = ~exp_d;
        seen++;
      end
    end
    chk("alt_count", seen, 8);
    ireq = 1'b0; dreq = 1'b0;
    repeat (4) tick();

    // LATENCY=3 store: one write cycle, DRD untouched
    reset = 1'b1; #1; reset = 1'b0;
    chk("st_pre_drd3", drd3, 0);
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h0040_0010; dwd = 32'hDEAD_BEEF;
    #1;
    chk("st_k0_memwe", mem_we3, 0);
    chk("st_k0_stallm", stallm3, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) begin dwd = 32'h1234_5678; daddr = 32'h0000_0000; dwe = 1'b0; end
      #1;
      chk($sformatf("st_k%0d_memwe", k), mem_we3, (k == 1) ? 1 : 0);
      chk($sformatf("st_k%0d_dready", k), dready3, (k == 4) ? 1 : 0);
      if (k <= 3) begin
        chk($sformatf("st_k%0d_memaddr", k), mem_addr3, 32'h0040_0010);
        chk($sformatf("st_k%0d_memwd", k), mem_wd3, 32'hDEAD_BEEF);
        chk($sformatf("st_k%0d_stallm", k), stallm3, 1);
      end
      if (k == 4) begin
        chk("st_drd_unchanged", drd3, 0);
        dreq = 1'b0;
      end
    end
    repeat (2) tick();

    // LATENCY=3 fetch, async reset while count=1, then full restart
    ireq = 1'b1; iaddr = 32'h0040_0040;
    tick();           // granted: count=2
    tick();           // count=1
    #2;
    reset = 1'b1;
    #1;
    chk("ar_memaddr3", mem_addr3, 0);
    chk("ar_iready3", iready3, 0);
    chk("ar_memwe3", mem_we3, 0);
    chk("ar_ird3", ird3, 0);
    chk("ar_stallf3", stallf3, 1);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("ar_k%0d_iready", k), iready3, (k == 4) ? 1 : 0);
      chk($sformatf("ar_k%0d_memaddr", k), mem_addr3, 32'h0040_0040);
      if (k == 4) begin
        chk("ar_ird_final", ird3, 32'hFFBF_FFBF);
        ireq = 1'b0;
      end
    end
    tick();
    chk("ar_post_iready", iready3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified Memory between two requesters: instruction fetch (I) and the MEM-stage data path (D).
- Arbitrates between them, sequences a fixed-latency access, and returns read data with a one-cycle ready pulse.
- Generates the stall signals StallF and StallM for the hazard unit.
- Sits between the fetch/MEM pipeline stages and Memory (address, WD, WE, RD).

Parameters:
- LATENCY, 1: ACCESS cycles per memory transaction; must be >= 1.
- WIDTH, 32: data/address width.

Ports:
- clock  in  1  posedge system clock (Memory itself acts on negedge inside the same cycle)
- reset  in  1  asynchronous, active-high
- IReq  in  1  fetch read request; held until IReady
- IAddr  in  WIDTH  fetch byte address
- IRD  out  WIDTH  fetch read data, registered
- IReady  out  1  one-cycle pulse; IRD valid
- DReq  in  1  data request; held until DReady
- DWE  in  1  1 = store, 0 = load
- DAddr  in  WIDTH  data byte address
- DWD  in  WIDTH  store data
- DRD  out  WIDTH  load data, registered
- DReady  out  1  one-cycle pulse; DRD valid / store done
- MemAddr  out  WIDTH  to Memory address
- MemWD  out  WIDTH  to Memory WD
- MemWE  out  1  to Memory WE
- MemRD  in  WIDTH  from Memory RD
- StallF  out  1  IReq & ~IReady
- StallM  out  1  DReq & ~DReady

Behaviour:
- Reset (async, any state): state=IDLE, count=0, grant=I, last_grant=I.
  - IRD, DRD, MemAddr, MemWD = 0.
  - IReady, DReady, MemWE = 0.
- Masking: in a cycle where IReady (DReady) is high, IReq (DReq) is masked from arbitration. The served requester must drop or update its request by the next cycle.
- IDLE, effective requests present:
  - Only one present: grant that one.
  - Both present: grant the opposite of last_grant. After reset last_grant=I, so D wins the first conflict.
  - At the edge: latch the address (and for D, DWD and DWE) into output registers; set grant and last_grant; state=ACCESS; count=LATENCY-1.
- IDLE, no effective request: outputs hold; MemWE=0.
- ACCESS:
  - MemAddr/MemWD are driven from the latched registers.
  - MemWE=1 only in the first ACCESS cycle and only for a D store; otherwise 0. A store therefore writes exactly once.
  - count>0: decrement.
  - count==0: capture MemRD into IRD or DRD (per grant; a D store does not update DRD); pulse the matching Ready for the next cycle; state=IDLE.
- Latency: request sampled in IDLE at edge t -> Ready high during cycle t+LATENCY+1. LATENCY=1 gives a 2-cycle access.
- Back-to-back accesses:
  - Same requester: minimum one-cycle bubble, because its request is masked in its Ready cycle.
  - Other requester: may be granted in that same Ready cycle (zero bubble).
- Requester drops its request mid-ACCESS: the access still completes and Ready still pulses. Arbiter state is unaffected.
- Inputs IAddr, DAddr, DWD, DWE may change during ACCESS without effect, because the latched copies are used.
- Ready pulses are exactly one cycle; IReady and DReady are never high together.
- StallF and StallM are combinational from request and Ready.
- No address range checking in this block; Memory reports unmapped accesses.

Test Plan:
1. LATENCY=1; IReq=1, IAddr=0x0040_0000, MemRD model returns 0x2008_0005 -> MemAddr=0x0040_0000 in ACCESS; IReady pulses 2 cycles after the request edge with IRD=0x2008_0005; StallF high for 2 cycles; MemWE stays 0.
2. Simultaneous IReq and DReq (load, DAddr=0x7FFF_FFFC) right after reset -> D served first, DReady at cycle 2; I granted in the DReady cycle, IReady at cycle 4; StallF high for 4 cycles.
3. Both requesters held continuously for 8 accesses -> grants strictly alternate D,I,D,I,...; no requester is starved; the Ready pulses never overlap.
4. D store (DWE=1, DAddr=0x0040_0010, DWD=0xDEAD_BEEF), LATENCY=3 -> MemWE high for exactly 1 cycle with MemWD=0xDEAD_BEEF; DReady at cycle 4; DRD unchanged.
5. reset asserted asynchronously mid-ACCESS (LATENCY=3, count=1) -> immediate IDLE; all outputs 0; no Ready pulse follows. After release, a pending IReq restarts the full latency.
6. IReq dropped and IAddr changed during ACCESS -> the original address is held on MemAddr; IReady still pulses once; the next grant proceeds normally.
